example_fifo: RTL

- Parametrised synchronous FIFO that buffers valid/data words between a producer and a consumer using ready/valid handshakes on both sides.
- Successor to the single-entry valid/data struct used in the example material: generalised data width and depth, with occupancy reporting and a synchronous flush.
- Sits between any two example-domain blocks that exchange valid/data payloads and need decoupling or rate smoothing.

---
 rtl/example_fifo.sv | 95 +++++++++
 1 files changed

// File: rtl/example_fifo.sv
// Parametrised first-word-fall-through FIFO with ready/valid on both sides,
// occupancy count and synchronous flush.
module example_fifo #(
    parameter  int DATA_WIDTH = 5,
    parameter  int DEPTH      = 4,
    localparam int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_flush,
    input  logic                  i_push_valid,
    output logic                  o_push_ready,
    input  logic [DATA_WIDTH-1:0] i_push_data,
    output logic                  o_pop_valid,
    input  logic                  i_pop_ready,
    output logic [DATA_WIDTH-1:0] o_pop_data,
    output logic [CNT_WIDTH-1:0]  o_count,
    output logic                  o_full,
    output logic                  o_empty
);

    localparam int PTR_WIDTH = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_WIDTH-1:0] PTR_LAST = PTR_WIDTH'(DEPTH - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_reg [DEPTH];
    logic [PTR_WIDTH-1:0]  wr_ptr_reg, wr_ptr_next;
    logic [PTR_WIDTH-1:0]  rd_ptr_reg, rd_ptr_next;
    logic [CNT_WIDTH-1:0]  count_reg, count_next;
    logic [DEPTH-1:0]      wr_en;
    logic                  push_fire;
    logic                  pop_fire;

    assign o_full       = (count_reg == CNT_FULL);
    assign o_empty      = (count_reg == '0);
    assign o_push_ready = !o_full;
    assign o_pop_valid  = !o_empty;
    assign o_count      = count_reg;
    assign o_pop_data   = mem_reg[rd_ptr_reg];

    assign push_fire = i_push_valid && o_push_ready;
    assign pop_fire  = o_pop_valid && i_pop_ready;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_wr_en
            assign wr_en[gi] = push_fire && (wr_ptr_reg == PTR_WIDTH'(gi));
        end
    endgenerate

    // Storage is left unreset; readers only look at it while count is non-zero.
    always_ff @(posedge i_clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_en[i]) begin
                mem_reg[i] <= i_push_data;
            end
        end
    end

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (i_flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (push_fire) begin
                wr_ptr_next = (wr_ptr_reg == PTR_LAST) ? '0 : wr_ptr_reg + 1'b1;
            end
            if (pop_fire) begin
                rd_ptr_next = (rd_ptr_reg == PTR_LAST) ? '0 : rd_ptr_reg + 1'b1;
            end
            case ({push_fire, pop_fire})
                2'b10:   count_next = count_reg + 1'b1;
                2'b01:   count_next = count_reg - 1'b1;
                default: count_next = count_reg;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

endmodule
